// File: rtl/l2_port_scheduler_if.sv
// rtl/l2_port_scheduler_if.sv - L1 I/D pmem sides and L2 port bundled for the port scheduler
interface l2_port_scheduler_if;
   logic         icache_read;
   logic [31:0]  icache_addr;
   logic         icache_resp;
   logic [255:0] icache_rdata;

   logic         dcache_read;
   logic         dcache_write;
   logic [31:0]  dcache_addr;
   logic [255:0] dcache_wdata;
   logic         dcache_resp;
   logic [255:0] dcache_rdata;

   logic         l2_read;
   logic         l2_write;
   logic [31:0]  l2_addr;
   logic [255:0] l2_wdata;
   logic         l2_resp;
   logic [255:0] l2_rdata;

   // master: the scheduler; slave: the L1 caches and the L2 around it
   modport master (
      input  icache_read, icache_addr,
      output icache_resp, icache_rdata,
      input  dcache_read, dcache_write, dcache_addr, dcache_wdata,
      output dcache_resp, dcache_rdata,
      output l2_read, l2_write, l2_addr, l2_wdata,
      input  l2_resp, l2_rdata
   );

   modport slave (
      output icache_read, icache_addr,
      input  icache_resp, icache_rdata,
      output dcache_read, dcache_write, dcache_addr, dcache_wdata,
      input  dcache_resp, dcache_rdata,
      input  l2_read, l2_write, l2_addr, l2_wdata,
      output l2_resp, l2_rdata
   );
endinterface

// File: rtl/l2_port_scheduler.sv
// rtl/l2_port_scheduler.sv - D-priority L2 port scheduler with bounded I starvation and grant counters
module l2_port_scheduler #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   l2_port_scheduler_if.master  bus,
   output logic [CNT_W-1:0]     i_grant_cnt,
   output logic [CNT_W-1:0]     d_grant_cnt
);
   localparam int              SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

   state_t            state_q;
   logic              l2_read_q;
   logic              l2_write_q;
   logic [31:0]       l2_addr_q;
   logic [255:0]      l2_wdata_q;
   logic [SW-1:0]     starve_q;
   logic [CNT_W-1:0]  i_cnt_q;
   logic [CNT_W-1:0]  d_cnt_q;

   logic i_req, d_req, grant_i, grant_d;

   always_comb begin
      d_req   = bus.dcache_read | bus.dcache_write;
      i_req   = bus.icache_read;
      grant_i = i_req & (~d_req | (starve_q == STARVE_MAX));
      grant_d = d_req & ~grant_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         l2_read_q  <= 1'b0;
         l2_write_q <= 1'b0;
         l2_addr_q  <= '0;
         l2_wdata_q <= '0;
         starve_q   <= '0;
         i_cnt_q    <= '0;
         d_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!i_req) starve_q <= '0;
               if (grant_i) begin
                  state_q    <= SERVE_I;
                  l2_addr_q  <= bus.icache_addr;
                  l2_read_q  <= 1'b1;
                  l2_write_q <= 1'b0;
                  starve_q   <= '0;
                  if (i_cnt_q != CNT_MAX) i_cnt_q <= i_cnt_q + 1'b1;
               end else if (grant_d) begin
                  // A simultaneous read+write from the D side is a writeback
                  state_q    <= SERVE_D;
                  l2_addr_q  <= bus.dcache_addr;
                  l2_read_q  <= ~bus.dcache_write;
                  l2_write_q <= bus.dcache_write;
                  if (bus.dcache_write) l2_wdata_q <= bus.dcache_wdata;
                  if (i_req && (starve_q != STARVE_MAX)) starve_q <= starve_q + 1'b1;
                  if (d_cnt_q != CNT_MAX) d_cnt_q <= d_cnt_q + 1'b1;
               end
            end
            SERVE_I, SERVE_D: begin
               if (bus.l2_resp) begin
                  l2_read_q  <= 1'b0;
                  l2_write_q <= 1'b0;
                  state_q    <= RECOVER;
               end
            end
            RECOVER: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Data is broadcast; only the resp strobe tells an L1 the line is for it
   assign bus.icache_resp  = (state_q == SERVE_I) & bus.l2_resp;
   assign bus.dcache_resp  = (state_q == SERVE_D) & bus.l2_resp;
   assign bus.icache_rdata = bus.l2_rdata;
   assign bus.dcache_rdata = bus.l2_rdata;

   assign bus.l2_read  = l2_read_q;
   assign bus.l2_write = l2_write_q;
   assign bus.l2_addr  = l2_addr_q;
   assign bus.l2_wdata = l2_wdata_q;

   assign i_grant_cnt = i_cnt_q;
   assign d_grant_cnt = d_cnt_q;
endmodule

// File: tb/tb_l2_port_scheduler.sv
// tb/tb_l2_port_scheduler.sv - directed and randomized bench for l2_port_scheduler
module tb_l2_port_scheduler;
   localparam int STARVE_LIMIT = 4;
   localparam int CNT_W        = 2;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;
   localparam logic [31:0]  I_TAG  = 32'h0000_0100;
   localparam logic [31:0]  D_TAG  = 32'h0000_2000;
   localparam logic [255:0] PAT_A5 = {32{8'hA5}};
   localparam logic [255:0] PAT_DB = {8{32'hDEADBEEF}};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   l2_port_scheduler_if bus();
   logic [CNT_W-1:0] i_grant_cnt, d_grant_cnt;

   l2_port_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
   );

   int n_vec = 0, n_err = 0;

   // Reference: port busy with one transaction, free two edges after its resp
   int           edge_no = 0, ready_edge = 0;
   bit           act = 0, act_i = 0;
   logic         exp_rd = 0, exp_wr = 0;
   logic [31:0]  exp_addr = '0;
   logic [255:0] exp_wdata = '0;
   int           exp_icnt = 0, exp_dcnt = 0, starve = 0;

   int   iresp_cnt = 0, dresp_cnt = 0;
   logic prev_req = 0;
   byte  grant_q[$];
   int   grant_edge_q[$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [255:0] wd,
                        input logic lr, input logic [255:0] lrd);
      bus.icache_read  = ir;
      bus.icache_addr  = ia;
      bus.dcache_read  = dr;
      bus.dcache_write = dw;
      bus.dcache_addr  = da;
      bus.dcache_wdata = wd;
      bus.l2_resp      = lr;
      bus.l2_rdata     = lrd;
   endtask

   task automatic model_edge();
      logic ir, dq;
      ir = bus.icache_read;
      dq = bus.dcache_read | bus.dcache_write;
      if (act) begin
         if (bus.l2_resp) begin
            act = 0; exp_rd = 0; exp_wr = 0;
            ready_edge = edge_no + 2;
         end
      end else if (edge_no >= ready_edge) begin
         if (!ir) starve = 0;
         if (ir && (!dq || starve == STARVE_LIMIT)) begin
            act = 1; act_i = 1;
            exp_addr = bus.icache_addr; exp_rd = 1; exp_wr = 0;
            starve = 0;
            exp_icnt = (exp_icnt < CNT_MAX) ? exp_icnt + 1 : CNT_MAX;
         end else if (dq) begin
            act = 1; act_i = 0;
            exp_addr = bus.dcache_addr;
            exp_wr = bus.dcache_write; exp_rd = !bus.dcache_write;
            if (bus.dcache_write) exp_wdata = bus.dcache_wdata;
            if (ir) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
            exp_dcnt = (exp_dcnt < CNT_MAX) ? exp_dcnt + 1 : CNT_MAX;
         end
      end
      edge_no++;
   endtask

   task automatic post_checks();
      chk("l2_read",  bus.l2_read,  exp_rd);
      chk("l2_write", bus.l2_write, exp_wr);
      chk("l2_addr",  bus.l2_addr,  exp_addr);
      chk("l2_wdata", bus.l2_wdata, exp_wdata);
      chk("i_grant_cnt", i_grant_cnt, exp_icnt);
      chk("d_grant_cnt", d_grant_cnt, exp_dcnt);
      if ((bus.l2_read | bus.l2_write) && !prev_req) begin
         grant_q.push_back((bus.l2_addr == I_TAG) ? "I" : "D");
         grant_edge_q.push_back(edge_no);
      end
      prev_req = bus.l2_read | bus.l2_write;
   endtask

   task automatic cycle();
      #1;
      chk("icache_resp",  bus.icache_resp,  act && act_i && bus.l2_resp);
      chk("dcache_resp",  bus.dcache_resp,  act && !act_i && bus.l2_resp);
      chk("icache_rdata", bus.icache_rdata, bus.l2_rdata);
      chk("dcache_rdata", bus.dcache_rdata, bus.l2_rdata);
      if (bus.icache_resp) iresp_cnt++;
      if (bus.dcache_resp) dresp_cnt++;
      model_edge();
      @(posedge clk);
      #1;
      post_checks();
   endtask

   task automatic do_reset();
      drive(0, '0, 0, 0, '0, '0, 0, '0);
      rst = 1'b1;
      act = 0; exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wdata = '0;
      exp_icnt = 0; exp_dcnt = 0; starve = 0;
      ready_edge = edge_no + 1;
      edge_no++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      post_checks();
   endtask

   initial begin
      bit ipend, dpend, dr, dw, lr, was_act;
      int lat_left, ir0, dr0, k;
      logic [31:0] ia, da;
      logic [255:0] wd;

      // Reset state
      do_reset();
      chk("rst_iresp", bus.icache_resp, 1'b0);
      chk("rst_dresp", bus.dcache_resp, 1'b0);

      // Lone I read, L2 answers on the second request cycle
      iresp_cnt = 0; dresp_cnt = 0;
      drive(1, 32'h60, 0, 0, '0, '0, 0, '0);   cycle();
      chk("lone_i_read", bus.l2_read, 1'b1);
      chk("lone_i_addr", bus.l2_addr, 32'h60);
      drive(1, 32'h60, 0, 0, '0, '0, 0, '0);   cycle();
      drive(1, 32'h60, 0, 0, '0, '0, 1, PAT_A5);
      #1;
      chk("lone_i_rdata", bus.icache_rdata, PAT_A5);
      cycle();
      drive(0, '0, 0, 0, '0, '0, 0, '0);       cycle();
      chk("lone_i_resp_pulses", iresp_cnt, 1);
      chk("lone_i_cnt", i_grant_cnt, 1);

      // D writeback with wdata changing mid-transaction
      iresp_cnt = 0; dresp_cnt = 0;
      drive(0, '0, 0, 1, 32'h1000, PAT_DB, 0, '0);   cycle();
      drive(0, '0, 0, 1, 32'h1000, ~PAT_DB, 0, '0);  cycle();
      chk("wb_write", bus.l2_write, 1'b1);
      chk("wb_wdata_hold", bus.l2_wdata, PAT_DB);
      drive(0, '0, 0, 1, 32'h1234, rnd256(), 1, rnd256()); cycle();
      drive(0, '0, 0, 0, '0, '0, 0, '0);             cycle();
      chk("wb_dresp_pulses", dresp_cnt, 1);
      chk("wb_no_iresp", iresp_cnt, 0);

      // Both sides request every cycle: D,D,D,D,I repeating
      do_reset();
      grant_q.delete(); grant_edge_q.delete();
      for (int c = 0; c < 60; c++) begin
         drive(1, I_TAG, 1, 0, D_TAG, '0, 1, rnd256());
         cycle();
      end
      chk("order_count_ok", grant_q.size() >= 15, 1'b1);
      for (int g = 0; g < 15 && g < grant_q.size(); g++)
         chk("grant_order", grant_q[g], (g % 5 == 4) ? "I" : "D");
      for (int g = 1; g < 15 && g < grant_edge_q.size(); g++)
         chk("grant_gap", grant_edge_q[g] - grant_edge_q[g-1], 3);

      // Reset while D is being served, then a late l2_resp
      do_reset();
      dresp_cnt = 0;
      drive(0, '0, 1, 0, D_TAG, '0, 0, '0);  cycle();
      drive(0, '0, 1, 0, D_TAG, '0, 0, '0);  cycle();
      do_reset();
      chk("rst_mid_l2_read", bus.l2_read, 1'b0);
      chk("rst_mid_dcnt", d_grant_cnt, 0);
      chk("rst_mid_icnt", i_grant_cnt, 0);
      drive(0, '0, 0, 0, '0, '0, 1, PAT_A5);  cycle();
      chk("late_resp_ignored", dresp_cnt, 0);

      // Saturation: five I grants on a 2-bit counter
      do_reset();
      for (int t = 0; t < 5; t++) begin
         drive(1, 32'h40 * t, 0, 0, '0, '0, 0, '0); cycle();
         drive(1, 32'h40 * t, 0, 0, '0, '0, 1, rnd256()); cycle();
         drive(0, '0, 0, 0, '0, '0, 0, '0); cycle();
      end
      chk("i_cnt_saturated", i_grant_cnt, 3);

      // Spurious l2_resp while idle
      iresp_cnt = 0; dresp_cnt = 0;
      for (int t = 0; t < 3; t++) begin
         drive(0, '0, 0, 0, '0, '0, 1, rnd256()); cycle();
      end
      chk("spurious_iresp", iresp_cnt, 0);
      chk("spurious_dresp", dresp_cnt, 0);

      // Randomized traffic against the reference
      ipend = 0; dpend = 0; dr = 0; dw = 0; was_act = 0; lat_left = 0;
      ia = '0; da = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            ipend = 0; dpend = 0; was_act = 0;
         end
         if (!ipend && $urandom_range(0, 1) == 1) ipend = 1;
         if (!dpend && $urandom_range(0, 1) == 1) begin
            dpend = 1;
            k = $urandom_range(0, 2);
            dr = (k != 1); dw = (k != 0);
         end
         ia = $urandom; da = $urandom; wd = rnd256();
         if (act && !was_act) lat_left = $urandom_range(0, 3);
         was_act = act;
         if (act) begin
            lr = (lat_left == 0);
            if (lat_left > 0) lat_left--;
         end else begin
            lr = ($urandom_range(0, 9) == 0);
         end
         ir0 = iresp_cnt; dr0 = dresp_cnt;
         drive(ipend, ia, dpend & dr, dpend & dw, da, wd, lr, rnd256());
         cycle();
         if (iresp_cnt != ir0) ipend = 0;
         if (dresp_cnt != dr0) dpend = 0;
         if (!act) was_act = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
